kmeans_ctrl: RTL and testbench

- Iteration sequencer for the 3-D k-means clustering datapath.
- Drives the point memory address, label writes and accumulator control.
- Issues handshaked requests to the nearest-centroid unit and the centroid-update (divider) unit.
- Runs INIT → repeated ASSIGN/UPDATE passes → stops on convergence or iteration limit, then raises `done` for the top level.

---
 rtl/kmeans_ctrl.sv | 175 +++++++++++++++++
 tb/tb_kmeans_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_ctrl.sv
// kmeans_ctrl: iteration sequencer for the 3-D k-means clustering datapath.
// Walks INIT -> (CLR, per-point ASSIGN, per-cluster UPDATE, CHECK)* -> DONE.
// It drives the point-memory address, label writes and accumulator strobes,
// and handshakes with the nearest-centroid and centroid-update units.
// Optional feature: define KMEANS_EARLY_STOP_EN to stop as soon as a pass
// (from the second one on) changes no labels; otherwise every run lasts
// exactly MAX_ITER iterations.
module kmeans_ctrl #(
    parameter int N_POINTS = 41,
    parameter int K        = 7,
    parameter int MAX_ITER = 16,
    parameter int ADDR_W   = 6,
    parameter int LBL_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [LBL_W-1:0]  pt_label_rd,
    output logic              lbl_we,
    output logic [LBL_W-1:0]  lbl_wdata,
    output logic              cen_init_we,
    output logic [LBL_W-1:0]  cen_idx,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              asg_start,
    input  logic              asg_done,
    input  logic [LBL_W-1:0]  asg_label,
    output logic              upd_start,
    input  logic              upd_done,
    output logic [7:0]        iter_cnt,
    output logic [ADDR_W-1:0] changes
);

    typedef enum logic [3:0] {
        IDLE, INIT, CLR, A_REQ, A_WAIT, A_WR, U_REQ, U_WAIT, CHECK, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PT    = ADDR_W'(N_POINTS - 1);
    localparam logic [LBL_W-1:0]  LAST_K     = LBL_W'(K - 1);
    localparam logic [7:0]        ITER_LIMIT = 8'(MAX_ITER);

    state_t     state;
    logic [7:0] iter_next;
    logic       stop;

    // pt_addr doubles as the point counter p and cen_idx as the cluster
    // counter k, so the addresses seen outside are the counters themselves.
    assign iter_next = iter_cnt + 8'd1;

`ifdef KMEANS_EARLY_STOP_EN
    // Converged once a pass after the first changes nothing, or limit hit.
    assign stop = (iter_next == ITER_LIMIT) ||
                  ((iter_next >= 8'd2) && (changes == '0));
`else
    // Fixed-length run: only the iteration limit ends it.
    assign stop = (iter_next == ITER_LIMIT);
`endif

    // Sequencer FSM with every output registered; strobes default low each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking (<=) so every register
            // samples pre-edge values; blocking here would create order races.
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pt_addr     <= '0;
            lbl_we      <= 1'b0;
            lbl_wdata   <= '0;
            cen_init_we <= 1'b0;
            cen_idx     <= '0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            asg_start   <= 1'b0;
            upd_start   <= 1'b0;
            iter_cnt    <= '0;
            changes     <= '0;
        end else begin
            cen_init_we <= 1'b0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            lbl_we      <= 1'b0;
            asg_start   <= 1'b0;
            upd_start   <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= INIT;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        iter_cnt    <= '0;
                        changes     <= '0;
                        pt_addr     <= '0;
                        cen_idx     <= '0;
                        cen_init_we <= 1'b1;
                    end
                end
                INIT: begin
                    // Seed centroid k with point k, one per cycle.
                    if (cen_idx == LAST_K) begin
                        state   <= CLR;
                        acc_clr <= 1'b1;
                    end else begin
                        pt_addr     <= pt_addr + 1'b1;
                        cen_idx     <= cen_idx + 1'b1;
                        cen_init_we <= 1'b1;
                    end
                end
                CLR: begin
                    // changes is cleared on leaving CLR so the finished pass
                    // stays visible for one cycle next to the bumped iter_cnt.
                    changes   <= '0;
                    pt_addr   <= '0;
                    asg_start <= 1'b1;
                    state     <= A_REQ;
                end
                A_REQ: state <= A_WAIT;
                A_WAIT: begin
                    if (asg_done) begin
                        lbl_wdata <= asg_label;
                        lbl_we    <= 1'b1;
                        acc_en    <= 1'b1;
                        state     <= A_WR;
                    end
                end
                A_WR: begin
                    // pt_label_rd still shows the old label during the write cycle.
                    if ((iter_cnt == 8'd0) || (lbl_wdata != pt_label_rd))
                        changes <= changes + 1'b1;
                    if (pt_addr == LAST_PT) begin
                        cen_idx   <= '0;
                        upd_start <= 1'b1;
                        state     <= U_REQ;
                    end else begin
                        pt_addr   <= pt_addr + 1'b1;
                        asg_start <= 1'b1;
                        state     <= A_REQ;
                    end
                end
                U_REQ: state <= U_WAIT;
                U_WAIT: begin
                    if (upd_done) begin
                        if (cen_idx == LAST_K) begin
                            state <= CHECK;
                        end else begin
                            cen_idx   <= cen_idx + 1'b1;
                            upd_start <= 1'b1;
                            state     <= U_REQ;
                        end
                    end
                end
                CHECK: begin
                    iter_cnt <= iter_next;
                    if (stop) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pt_addr   <= '0;
                        cen_idx   <= '0;
                        lbl_wdata <= '0;
                    end else begin
                        state   <= CLR;
                        acc_clr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_ctrl.sv
// tb_kmeans_ctrl: directed bench for kmeans_ctrl with behavioural models of
// the label memory, accumulators, nearest-centroid and update units.
// Expected values follow the KMEANS_EARLY_STOP_EN setting of the build.
module tb_kmeans_ctrl;

    localparam int N      = 41;
    localparam int KC     = 7;
    localparam int MAXI   = 16;
    localparam int AW     = 6;
    localparam int LW     = 3;
    localparam int LIMIT  = 8000;

`ifdef KMEANS_EARLY_STOP_EN
    localparam int EXP_ITER     = 2;
    localparam int EXP_MOCK_CYC = 506;   // 1 + 7 + 2*(1 + 41*5 + 7*6 + 1)
    localparam int EXP_REAL_CYC = 286;   // 1 + 7 + 2*(1 + 41*3 + 7*2 + 1)
`else
    localparam int EXP_ITER     = 16;
    localparam int EXP_MOCK_CYC = 3992;  // 1 + 7 + 16*249
    localparam int EXP_REAL_CYC = 2232;  // 1 + 7 + 16*139
`endif

    logic          clk, rst, start;
    logic          busy, done, lbl_we, cen_init_we, acc_clr, acc_en;
    logic          asg_start, asg_done, upd_start, upd_done;
    logic [AW-1:0] pt_addr, changes;
    logic [LW-1:0] pt_label_rd, lbl_wdata, cen_idx, asg_label;
    logic [7:0]    iter_cnt;
    logic [63:0]   outs;

    // Bench-driven controls and model state.
    logic          asg_force;
    bit            mode_const;
    int            lat_a, lat_u;
    int            px [0:N-1], py [0:N-1], pz [0:N-1];
    int            exp_lbl [0:N-1];
    int            cx [0:KC-1], cy [0:KC-1], cz [0:KC-1];
    int            sx [0:KC-1], sy [0:KC-1], sz [0:KC-1], cnt [0:KC-1];
    logic [LW-1:0] lbl_mem [0:N-1];
    logic [LW-1:0] a_label;
    int            a_timer, u_timer, u_idx;

    int n_checks = 0;
    int n_fail   = 0;

    kmeans_ctrl #(
        .N_POINTS(N), .K(KC), .MAX_ITER(MAXI), .ADDR_W(AW), .LBL_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pt_addr(pt_addr), .pt_label_rd(pt_label_rd), .lbl_we(lbl_we),
        .lbl_wdata(lbl_wdata), .cen_init_we(cen_init_we), .cen_idx(cen_idx),
        .acc_clr(acc_clr), .acc_en(acc_en), .asg_start(asg_start),
        .asg_done(asg_done), .asg_label(asg_label), .upd_start(upd_start),
        .upd_done(upd_done), .iter_cnt(iter_cnt), .changes(changes)
    );

    assign outs = {30'd0, busy, done, pt_addr, lbl_we, lbl_wdata, cen_init_we,
                   cen_idx, acc_clr, acc_en, asg_start, upd_start, iter_cnt, changes};
    assign pt_label_rd = (int'(pt_addr) < N) ? lbl_mem[int'(pt_addr)] : '0;
    assign asg_done    = (a_timer == 1) || asg_force;
    assign asg_label   = a_label;
    assign upd_done    = (u_timer == 1);

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] nearest(input int i);
        int best, bd, d;
        best = 0;
        bd   = 32'h7fffffff;
        for (int k = 0; k < KC; k++) begin
            d = (px[i]-cx[k])*(px[i]-cx[k]) + (py[i]-cy[k])*(py[i]-cy[k]) +
                (pz[i]-cz[k])*(pz[i]-cz[k]);
            if (d < bd) begin
                bd   = d;
                best = k;
            end
        end
        return LW'(best);
    endfunction

    // Datapath model: latency-driven units, accumulators, centroids, label memory.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_timer <= 0;
            u_timer <= 0;
        end else begin
            if (asg_start) begin
                a_timer <= lat_a;
                a_label <= mode_const ? LW'(3) : nearest(int'(pt_addr));
            end else if (a_timer != 0) begin
                a_timer <= a_timer - 1;
            end
            if (upd_start) begin
                u_timer <= lat_u;
                u_idx   <= int'(cen_idx);
            end else if (u_timer != 0) begin
                u_timer <= u_timer - 1;
            end
            if (u_timer == 1 && cnt[u_idx] != 0) begin
                cx[u_idx] <= sx[u_idx] / cnt[u_idx];
                cy[u_idx] <= sy[u_idx] / cnt[u_idx];
                cz[u_idx] <= sz[u_idx] / cnt[u_idx];
            end
            if (cen_init_we) begin
                cx[cen_idx] <= px[pt_addr];
                cy[cen_idx] <= py[pt_addr];
                cz[cen_idx] <= pz[pt_addr];
            end
            if (acc_clr) begin
                for (int k = 0; k < KC; k++) begin
                    sx[k]  <= 0;
                    sy[k]  <= 0;
                    sz[k]  <= 0;
                    cnt[k] <= 0;
                end
            end
            if (acc_en) begin
                sx[lbl_wdata]  <= sx[lbl_wdata] + px[pt_addr];
                sy[lbl_wdata]  <= sy[lbl_wdata] + py[pt_addr];
                sz[lbl_wdata]  <= sz[lbl_wdata] + pz[pt_addr];
                cnt[lbl_wdata] <= cnt[lbl_wdata] + 1;
            end
            if (lbl_we) lbl_mem[pt_addr] <= lbl_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a run and count clock edges until done; optionally pulse start
    // in A_WR and a stray asg_done in U_WAIT, which must change nothing.
    task automatic run(input bit inject, output int cyc, output int ch1);
        bit sent_s, sent_a, pend_a;
        sent_s = 0;
        sent_a = 0;
        pend_a = 0;
        cyc    = 0;
        ch1    = -1;
        @(negedge clk);
        start = 1'b1;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start     = 1'b0;
            asg_force = 1'b0;
            if (cyc == 1) begin
                check("go_busy", busy, 1);
                check("go_done", done, 0);
                check("go_iter", iter_cnt, 0);
                check("go_init", {cen_init_we, pt_addr}, 1 << AW);
            end
            if (iter_cnt == 8'd1 && ch1 < 0) ch1 = int'(changes);
            if (inject) begin
                if (lbl_we && !sent_s) begin
                    start  = 1'b1;
                    sent_s = 1;
                end
                if (pend_a) begin
                    asg_force = 1'b1;
                    pend_a    = 0;
                    sent_a    = 1;
                end
                if (upd_start && !sent_a) pend_a = 1;
            end
        end while (!done && cyc < LIMIT);
        check("run_done", done, 1);
    endtask

    initial begin
        int cyc, ch1, j, w;
        rst        = 1'b1;
        start      = 1'b0;
        asg_force  = 1'b0;
        mode_const = 1'b1;
        lat_a      = 3;
        lat_u      = 5;

        // Points 0..6 seed one tight cluster each, 7..34 fill the clusters,
        // 35..40 are outliers attached to clusters 0..5.
        for (int i = 0; i < N; i++) begin
            if (i < KC)      j = i;
            else if (i < 35) j = (i - KC) / 4;
            else             j = i - 35;
            exp_lbl[i] = j;
            if (i < 35) begin
                px[i] = 100 + 200*j + (i % 5) - 2;
                py[i] = 1500 - 200*j + ((i*3) % 5) - 2;
                pz[i] = 100 + 150*j + ((i*7) % 5) - 2;
            end else begin
                px[i] = 100 + 200*j + 30;
                py[i] = 1500 - 200*j - 20;
                pz[i] = 100 + 150*j + 10;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", outs, 0);
        @(negedge clk);
        rst = 1'b0;

        // Abort a run while waiting on the assignment unit.
        @(negedge clk);
        start = 1'b1;
        w = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            w++;
        end while (!asg_start && w < 50);
        check("abort_reach", asg_start, 1);
        @(posedge clk);
        #1;
        check("abort_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_async", outs, 0);
        @(posedge clk);
        #1;
        check("abort_edge", outs, 0);
        @(negedge clk);
        rst = 1'b0;

        // Constant-label mock, L=3, M=5, starting from IDLE.
        run(0, cyc, ch1);
        check("mock_cycles", cyc, EXP_MOCK_CYC);
        check("mock_ch1", ch1, 41);
        check("mock_iter", iter_cnt, EXP_ITER);
        check("mock_changes", changes, 0);
        check("mock_busy", busy, 0);

        // Restart from DONE with ignored start / asg_done pulses injected.
        run(1, cyc, ch1);
        check("inj_cycles", cyc, EXP_MOCK_CYC);
        check("inj_ch1", ch1, 41);
        check("inj_iter", iter_cnt, EXP_ITER);
        check("inj_changes", changes, 0);

        // Real nearest-centroid datapath, L=1, M=1.
        mode_const = 1'b0;
        lat_a      = 1;
        lat_u      = 1;
        run(0, cyc, ch1);
        check("real_cycles", cyc, EXP_REAL_CYC);
        check("real_ch1", ch1, 41);
        check("real_iter", iter_cnt, EXP_ITER);
        check("real_changes", changes, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("label%0d", i), lbl_mem[i], exp_lbl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
